custom_leds_pwm: RTL and testbench

CUSTOM_LEDS_PWM -- requirements
Module: custom_leds_pwm

---
 rtl/custom_leds_pwm.sv | 180 ++++++++++++++++++
 tb/tb_custom_leds_pwm.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_leds_pwm.sv
// custom_leds_pwm: Avalon-MM controlled LED bank for the HPS lightweight bridge.
// Features a scrolling pattern driven by a programmable prescale tick, and a
// global 8-bit PWM brightness gate. Registered LED outputs and 1-cycle reads.
`timescale 1ns/1ps
module custom_leds_pwm #(
  parameter logic [15:0] PRESCALE_RST = 16'd49999,
  parameter logic [7:0]  BRIGHT_RST   = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_s0_address,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  input  logic        avs_s0_read,
  output logic [31:0] avs_s0_readdata,
  output logic [7:0]  leds
);

  // Word addresses of the register map
  localparam logic [2:0] ADDR_PATTERN  = 3'd0;
  localparam logic [2:0] ADDR_CTRL     = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_BRIGHT   = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;

  // CTRL bit positions
  localparam int CTRL_PWM_EN    = 0;
  localparam int CTRL_SCROLL_EN = 1;

  // Architectural registers
  logic [7:0]  pattern_q, pattern_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] prescale_q, prescale_d;
  logic [7:0]  bright_q, bright_d;
  logic        tick_seen_q, tick_seen_d;

  // Internal counters and output registers
  logic [15:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  leds_q, leds_d;
  logic [31:0] readdata_q, readdata_d;

  // High only during the first cycle after reset is released; masks the tick
  // there so a PRESCALE_RST of zero cannot rotate the pattern immediately.
  logic        post_rst_q;

  // Bus decode strobes
  logic        wr_pattern;
  logic        wr_ctrl;
  logic        wr_prescale;
  logic        wr_bright;
  logic        rd_status;

  // Datapath helpers
  logic        tick;
  logic        pwm_on;
  logic [31:0] rd_mux;

  // Only the low 16 bits of write data ever land in a register.
  logic        unused_wdata;
  assign unused_wdata = ^avs_s0_writedata[31:16];

  // Address decode for writes (STATUS and 5-7 have no write target) and the STATUS read side effect
  always_comb begin
    wr_pattern  = 1'b0;
    wr_ctrl     = 1'b0;
    wr_prescale = 1'b0;
    wr_bright   = 1'b0;
    rd_status   = 1'b0;
    if (avs_s0_write) begin
      case (avs_s0_address)
        ADDR_PATTERN:  wr_pattern  = 1'b1;
        ADDR_CTRL:     wr_ctrl     = 1'b1;
        ADDR_PRESCALE: wr_prescale = 1'b1;
        ADDR_BRIGHT:   wr_bright   = 1'b1;
        default:       ;
      endcase
    end
    if (avs_s0_read && (avs_s0_address == ADDR_STATUS)) begin
      rd_status = 1'b1;
    end
  end

  // Prescaler: count up, fire a one-cycle tick once the count reaches PRESCALE, then restart from 0
  always_comb begin
    tick = !post_rst_q && (presc_cnt_q >= prescale_q);
    presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
    // A pattern write realigns the scroll phase to the new pattern.
    if (wr_pattern) begin
      presc_cnt_d = 16'd0;
    end
  end

  // Pattern: a bus write wins over the scroll rotation when both land in the same cycle
  always_comb begin
    pattern_d = pattern_q;
    if (wr_pattern) begin
      pattern_d = avs_s0_writedata[7:0];
    end else if (tick && ctrl_q[CTRL_SCROLL_EN]) begin
      pattern_d = {pattern_q[6:0], pattern_q[7]};
    end
  end

  // Plain RW control registers
  always_comb begin
    ctrl_d     = wr_ctrl     ? avs_s0_writedata[1:0]  : ctrl_q;
    prescale_d = wr_prescale ? avs_s0_writedata[15:0] : prescale_q;
    bright_d   = wr_bright   ? avs_s0_writedata[7:0]  : bright_q;
  end

  // Sticky tick flag: a tick always sets it, so a read racing a tick cannot lose that tick
  always_comb begin
    tick_seen_d = tick_seen_q;
    if (tick) begin
      tick_seen_d = 1'b1;
    end else if (rd_status) begin
      tick_seen_d = 1'b0;
    end
  end

  // PWM: free-running 8-bit phase; full brightness forces the gate on for all 256 phases
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_on    = (pwm_cnt_q < bright_q) || (bright_q == 8'hFF);
  end

  // LED drive: gate the pattern with the PWM phase when PWM is enabled
  always_comb begin
    if (ctrl_q[CTRL_PWM_EN]) begin
      leds_d = pattern_q & {8{pwm_on}};
    end else begin
      leds_d = pattern_q;
    end
  end

  // Read mux uses current (pre-write) register values; unused bits and unmapped words read as 0
  always_comb begin
    rd_mux = 32'h0;
    case (avs_s0_address)
      ADDR_PATTERN:  rd_mux = {24'h0, pattern_q};
      ADDR_CTRL:     rd_mux = {30'h0, ctrl_q};
      ADDR_PRESCALE: rd_mux = {16'h0, prescale_q};
      ADDR_BRIGHT:   rd_mux = {24'h0, bright_q};
      ADDR_STATUS:   rd_mux = {23'h0, tick_seen_q, pattern_q};
      default:       rd_mux = 32'h0;
    endcase
    readdata_d = avs_s0_read ? rd_mux : readdata_q;
  end

  // State update; reset discards any same-cycle bus access
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q   <= 8'h00;
      ctrl_q      <= 2'b00;
      prescale_q  <= PRESCALE_RST;
      bright_q    <= BRIGHT_RST;
      tick_seen_q <= 1'b0;
      presc_cnt_q <= 16'd0;
      pwm_cnt_q   <= 8'd0;
      leds_q      <= 8'h00;
      readdata_q  <= 32'h0;
      post_rst_q  <= 1'b1;
    end else begin
      pattern_q   <= pattern_d;
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      bright_q    <= bright_d;
      tick_seen_q <= tick_seen_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      leds_q      <= leds_d;
      readdata_q  <= readdata_d;
      post_rst_q  <= 1'b0;
    end
  end

  assign avs_s0_readdata = readdata_q;
  assign leds            = leds_q;

endmodule

// File: tb/tb_custom_leds_pwm.sv
// Testbench for custom_leds_pwm: directed bus traffic with a queue-based
// scoreboard. Read responses and LED values are checked by a monitor process.
`timescale 1ns/1ps
module tb_custom_leds_pwm;

  localparam logic [15:0] PRST = 16'd20;
  localparam logic [31:0] FULL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_s0_address;
  logic        avs_s0_write;
  logic [31:0] avs_s0_writedata;
  logic        avs_s0_read;
  logic [31:0] avs_s0_readdata;
  logic [7:0]  leds;

  custom_leds_pwm #(
    .PRESCALE_RST(PRST),
    .BRIGHT_RST  (8'd255)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_s0_address  (avs_s0_address),
    .avs_s0_write    (avs_s0_write),
    .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_read     (avs_s0_read),
    .avs_s0_readdata (avs_s0_readdata),
    .leds            (leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    logic [31:0] mask;
    string       name;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    logic [7:0]  val;
    string       name;
  } led_exp_t;

  rd_exp_t  rd_q[$];
  led_exp_t led_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rst_cyc  = 0;
  logic        mon_rst;
  logic        mon_rd_fire;
  logic [31:0] prev_rd = 32'h0;

  // Monitor: samples strobes at the edge, checks DUT outputs 1 ns later.
  always begin
    @(posedge clk);
    mon_rst     = reset;
    mon_rd_fire = avs_s0_read && !reset;
    cyc         = cyc + 1;
    if (mon_rst) rst_cyc = cyc;
    #1;
    if (mon_rst) begin
      n_checks += 2;
      if (leds !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_leds cyc %0d: got %h expected 00", cyc, leds);
      end
      if (avs_s0_readdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_readdata cyc %0d: got %h expected 00000000", cyc, avs_s0_readdata);
      end
    end else if (mon_rd_fire) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read cyc %0d: got %h expected no response", cyc, avs_s0_readdata);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        if ((avs_s0_readdata & e.mask) !== e.val) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %h expected %h (mask %h)", e.name, cyc, avs_s0_readdata, e.val, e.mask);
        end else begin
          $display("read  %-22s cyc %0d: %h", e.name, cyc, avs_s0_readdata);
        end
      end
    end else begin
      n_checks++;
      if (avs_s0_readdata !== prev_rd) begin
        n_fail++;
        $display("FAIL readdata_hold cyc %0d: got %h expected %h", cyc, avs_s0_readdata, prev_rd);
      end
    end
    prev_rd = avs_s0_readdata;
    while (led_q.size() != 0 && led_q[0].cyc <= cyc) begin
      led_exp_t l;
      l = led_q.pop_front();
      n_checks++;
      if (l.cyc < cyc) begin
        n_fail++;
        $display("FAIL led_missed %s: got cyc %0d expected cyc %0d", l.name, cyc, l.cyc);
      end else if (leds !== l.val) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %h expected %h", l.name, cyc, leds, l.val);
      end
    end
  end

  // Stimulus helpers: each is entered at a falling edge and consumes one cycle.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_s0_address   = a;
    avs_s0_writedata = d;
    avs_s0_write     = 1'b1;
    $display("write addr %0d data %h cyc %0d", a, d, cyc);
    @(negedge clk);
    avs_s0_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] v, input logic [31:0] m, input string nm);
    rd_exp_t e;
    e.val  = v;
    e.mask = m;
    e.name = nm;
    rd_q.push_back(e);
    avs_s0_address = a;
    avs_s0_read    = 1'b1;
    @(negedge clk);
    avs_s0_read = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] v, input string nm);
    rd_exp_t e;
    e.val  = v;
    e.mask = FULL;
    e.name = nm;
    rd_q.push_back(e);
    avs_s0_address   = a;
    avs_s0_writedata = d;
    avs_s0_read      = 1'b1;
    avs_s0_write     = 1'b1;
    @(negedge clk);
    avs_s0_read  = 1'b0;
    avs_s0_write = 1'b0;
  endtask

  // Queue an LED expectation for the given cycle, keeping the queue ordered.
  task automatic exp_led(input int c, input logic [7:0] v, input string nm);
    led_exp_t l;
    int       i;
    l.cyc  = c;
    l.val  = v;
    l.name = nm;
    i = led_q.size();
    while (i > 0 && led_q[i-1].cyc > c) i--;
    led_q.insert(i, l);
  endtask

  initial begin
    int w, p, q, e, a, b, z, r;
    reset            = 1'b1;
    avs_s0_address   = 3'd0;
    avs_s0_write     = 1'b0;
    avs_s0_writedata = 32'h0;
    avs_s0_read      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values of every word
    exp_led(cyc + 2, 8'h00, "rst_leds");
    rd(3'd0, 32'h0, FULL, "rst_pattern");
    rd(3'd1, 32'h0, FULL, "rst_ctrl");
    rd(3'd2, 32'(PRST), FULL, "rst_prescale");
    rd(3'd3, 32'd255, FULL, "rst_bright");
    rd(3'd4, 32'h0, FULL, "rst_status");
    rd(3'd5, 32'h0, FULL, "rst_addr5");
    rd(3'd6, 32'h0, FULL, "rst_addr6");
    rd(3'd7, 32'h0, FULL, "rst_addr7");

    // Static pattern reaches leds two cycles after the write strobe
    w = cyc;
    exp_led(w + 1, 8'h00, "a5_before");
    exp_led(w + 2, 8'hA5, "a5_leds");
    wr(3'd0, 32'hFFFF_FFA5);
    rd(3'd0, 32'h0000_00A5, FULL, "pattern_a5");

    // Upper write bits ignored, zero on read
    wr(3'd3, 32'hFFFF_FF40);
    rd(3'd3, 32'h0000_0040, FULL, "bright_trunc");
    wr(3'd2, 32'hABCD_1234);
    rd(3'd2, 32'h0000_1234, FULL, "prescale_trunc");
    wr(3'd1, 32'hFFFF_FFFC);
    rd(3'd1, 32'h0, FULL, "ctrl_trunc");

    // Scroll with PRESCALE = 3: 81 -> 03 -> 06 -> 0C every 4 cycles
    wr(3'd2, 32'd3);
    wr(3'd1, 32'd2);
    w = cyc;
    exp_led(w + 2,  8'h81, "scroll_81_first");
    exp_led(w + 5,  8'h81, "scroll_81_last");
    exp_led(w + 6,  8'h03, "scroll_03_first");
    exp_led(w + 9,  8'h03, "scroll_03_last");
    exp_led(w + 10, 8'h06, "scroll_06");
    wr(3'd0, 32'h81);
    idle(8);
    rd(3'd4, 32'h106, FULL, "status_06_tick");
    rd(3'd4, 32'h006, FULL, "status_cleared");
    idle(1);
    rd(3'd4, 32'h006, FULL, "status_rd_vs_tick");
    rd(3'd4, 32'h10C, FULL, "status_tick_kept");

    // Lowering PRESCALE below the count ticks on the next cycle
    wr(3'd2, 32'd100);
    p = cyc;
    wr(3'd0, 32'h11);
    idle(11);
    q = cyc;
    exp_led(q + 2, 8'h11, "lower_before");
    exp_led(q + 3, 8'h22, "lower_tick");
    exp_led(q + 8, 8'h22, "lower_restart");
    exp_led(q + 9, 8'h44, "lower_next_tick");
    wr(3'd2, 32'd5);
    idle(9);
    if (q - p != 12) $display("note: scheduling offset %0d", q - p);

    // PRESCALE = 0: rotate every cycle; pattern write coinciding with a tick wins
    wr(3'd2, 32'd0);
    e = cyc;
    exp_led(e + 2, 8'h01, "p0_load");
    exp_led(e + 3, 8'h02, "p0_rot1");
    exp_led(e + 4, 8'h04, "p0_rot2");
    exp_led(e + 5, 8'h08, "p0_rot3");
    wr(3'd0, 32'h01);
    idle(5);

    // PWM gate: brightness 64, 255 and 0 over full 256-cycle periods
    wr(3'd1, 32'd1);
    wr(3'd0, 32'hFF);
    a = cyc;
    wr(3'd3, 32'd64);
    for (int x = a + 2; x < a + 2 + 256; x++) begin
      exp_led(x, (((x - 1 - rst_cyc) % 256) < 64) ? 8'hFF : 8'h00, "pwm_b64");
    end
    idle(256);
    b = cyc;
    wr(3'd3, 32'd255);
    for (int x = b + 2; x < b + 2 + 256; x++) exp_led(x, 8'hFF, "pwm_b255");
    idle(256);
    z = cyc;
    wr(3'd3, 32'd0);
    for (int x = z + 2; x < z + 2 + 256; x++) exp_led(x, 8'h00, "pwm_b0");
    idle(256);

    // Unmapped/read-only addresses and read-before-write on a collision
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd1000);
    wr(3'd0, 32'h3C);
    rd(3'd4, 32'h03C, 32'hFFFF_FEFF, "status_pre");
    rd(3'd6, 32'h0, FULL, "addr6_zero");
    wr(3'd4, FULL);
    wr(3'd5, FULL);
    wr(3'd7, FULL);
    rd(3'd4, 32'h03C, FULL, "status_ro");
    rd(3'd0, 32'h03C, FULL, "pattern_unchanged");
    rdwr(3'd3, 32'h99, 32'h0, "rw_same_old");
    rd(3'd3, 32'h99, FULL, "rw_same_new");

    // Mid-operation reset with a colliding read and write
    wr(3'd2, 32'd2);
    wr(3'd1, 32'd3);
    rd(3'd1, 32'd3, FULL, "ctrl_both");
    wr(3'd3, 32'h80);
    wr(3'd0, 32'h81);
    idle(5);
    r = cyc;
    for (int x = r + 2; x < r + 12; x++) exp_led(x, 8'h00, "post_rst_leds");
    reset            = 1'b1;
    avs_s0_address   = 3'd0;
    avs_s0_writedata = 32'h55;
    avs_s0_write     = 1'b1;
    avs_s0_read      = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    avs_s0_write = 1'b0;
    avs_s0_read  = 1'b0;
    for (int k = 0; k <= int'(PRST) + 1; k++) begin
      rd(3'd4, (k == int'(PRST) + 1) ? 32'h100 : 32'h0, FULL, "post_rst_status");
    end
    rd(3'd0, 32'h0, FULL, "post_rst_pattern");
    rd(3'd1, 32'h0, FULL, "post_rst_ctrl");
    rd(3'd2, 32'(PRST), FULL, "post_rst_prescale");
    rd(3'd3, 32'd255, FULL, "post_rst_bright");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 50 && (rd_q.size() != 0 || led_q.size() != 0); i++) @(negedge clk);
    n_checks++;
    if (rd_q.size() != 0 || led_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d reads %0d leds pending expected 0", rd_q.size(), led_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
